// File: rtl/or1200_key_load_ctrl_pkg.sv
// Shared constants and state encodings for the OR1200 key load controller.
// The controller FSM states are binary-encoded over 3 bits.
package or1200_key_load_ctrl_pkg;

    localparam int unsigned KEY_W = 128;

    localparam logic [2:0] OR1200_KEYCTRL_IDLE   = 3'd0;
    localparam logic [2:0] OR1200_KEYCTRL_FILL   = 3'd1;
    localparam logic [2:0] OR1200_KEYCTRL_PEND   = 3'd2;
    localparam logic [2:0] OR1200_KEYCTRL_COMMIT = 3'd3;
    localparam logic [2:0] OR1200_KEYCTRL_ZERO   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = OR1200_KEYCTRL_IDLE,
        StFill   = OR1200_KEYCTRL_FILL,
        StPend   = OR1200_KEYCTRL_PEND,
        StCommit = OR1200_KEYCTRL_COMMIT,
        StZero   = OR1200_KEYCTRL_ZERO
    } keyctrl_state_e;

endpackage

// File: rtl/or1200_key_load_ctrl_if.sv
// Bus-side word writes, engine handshake and key register load signals.
// The slave modport is the controller; the master modport drives it.
interface or1200_key_load_ctrl_if #(
    parameter int unsigned WORD_W = 32
);
    import or1200_key_load_ctrl_pkg::*;

    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              abort;
    logic              kill;
    logic              use_start;
    logic              use_done;
    logic              reg_ce;
    logic [KEY_W-1:0]  reg_in;
    logic              key_valid;
    logic              load_busy;
    logic              commit_pend;
    logic              err_drop;

    modport master (
        output wr_en, wr_data, abort, kill, use_start, use_done,
        input  reg_ce, reg_in, key_valid, load_busy, commit_pend, err_drop
    );

    modport slave (
        input  wr_en, wr_data, abort, kill, use_start, use_done,
        output reg_ce, reg_in, key_valid, load_busy, commit_pend, err_drop
    );

endinterface

// File: rtl/or1200_key_load_ctrl.sv
// Stages NWORDS bus words into a key buffer and commits it to the external
// 128-bit key register with a one-cycle ce pulse once the engine is idle.
module or1200_key_load_ctrl
    import or1200_key_load_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    or1200_key_load_ctrl_if.slave bus
);

    localparam int unsigned CntW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    generate
        if (WORD_W * NWORDS != KEY_W) begin : g_bad_geometry
            $error("WORD_W*NWORDS must equal 128");
        end
    endgenerate

    keyctrl_state_e   state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [KEY_W-1:0] stage_q, stage_d;
    logic             in_use_q, in_use_d;
    logic             key_valid_q, key_valid_d;
    logic             err_q, err_d;
    logic             in_use_nxt;
    logic             last_word;

    always_comb begin
        // Engine ownership after this cycle's handshake; done+start keeps it busy.
        in_use_nxt  = (in_use_q & ~bus.use_done) | (bus.use_start & key_valid_q);
        last_word   = (cnt_q == CntW'(NWORDS - 1));

        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        in_use_d    = in_use_nxt;
        err_d       = err_q;
        key_valid_d = key_valid_q;

        // The register output follows reg_ce by one edge, so validity does too.
        if (state_q == StCommit) begin
            key_valid_d = 1'b1;
        end else if (state_q == StZero) begin
            key_valid_d = 1'b0;
        end

        if (bus.kill) begin
            state_d  = StZero;
            cnt_d    = '0;
            stage_d  = '0;
            in_use_d = 1'b0;
            err_d    = 1'b0;
        end else if (bus.abort && (state_q != StZero)) begin
            state_d = StIdle;
            cnt_d   = '0;
            stage_d = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFill: begin
                    if (bus.wr_en) begin
                        stage_d[int'(cnt_q) * WORD_W +: WORD_W] = bus.wr_data;
                        if (last_word) begin
                            cnt_d   = '0;
                            state_d = in_use_nxt ? StPend : StCommit;
                        end else begin
                            cnt_d   = cnt_q + CntW'(1);
                            state_d = StFill;
                        end
                    end
                end
                StPend: begin
                    if (!in_use_nxt) begin
                        state_d = StCommit;
                    end
                    if (bus.wr_en) begin
                        err_d = 1'b1;
                    end
                end
                StCommit, StZero: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    stage_d = '0;
                    if (bus.wr_en) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stage_q     <= '0;
            in_use_q    <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            in_use_q    <= in_use_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end

    // Staging contents reach reg_in only during COMMIT.
    assign bus.reg_ce      = (state_q == StCommit) || (state_q == StZero);
    assign bus.reg_in      = (state_q == StCommit) ? stage_q : '0;
    assign bus.key_valid   = key_valid_q;
    assign bus.load_busy   = (state_q == StFill) || (state_q == StPend);
    assign bus.commit_pend = (state_q == StPend);
    assign bus.err_drop    = err_q;

endmodule

// File: tb/tb_or1200_key_load_ctrl.sv
// Directed scenarios plus random traffic against a queue-based key load model.
module tb_or1200_key_load_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    or1200_key_load_ctrl_if #(.WORD_W(32)) bus ();

    or1200_key_load_ctrl #(
        .WORD_W(32),
        .NWORDS(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words accepted so far, plus flags for what the
    // register sees this cycle.
    logic [31:0]  m_words[$];
    bit           m_pend, m_commit, m_zero, m_in_use, m_kv, m_err;
    logic [127:0] m_val;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_eq("reg_ce", 128'(bus.reg_ce), 128'(m_commit || m_zero));
        check_eq("reg_in", bus.reg_in, m_commit ? m_val : 128'h0);
        check_eq("key_valid", 128'(bus.key_valid), 128'(m_kv));
        check_eq("load_busy", 128'(bus.load_busy), 128'(m_pend || (m_words.size() != 0)));
        check_eq("commit_pend", 128'(bus.commit_pend), 128'(m_pend));
        check_eq("err_drop", 128'(bus.err_drop), 128'(m_err));
    endtask

    task automatic start_commit();
        m_val = '0;
        for (int i = 0; i < m_words.size(); i++) m_val[32*i +: 32] = m_words[i];
        m_commit = 1'b1;
        m_words.delete();
    endtask

    task automatic drive(input bit r, input bit k, input bit a, input bit w,
                         input logic [31:0] d, input bit us, input bit ud);
        bit nu;
        bit kvn;
        rst           = r;
        bus.kill      = k;
        bus.abort     = a;
        bus.wr_en     = w;
        bus.wr_data   = d;
        bus.use_start = us;
        bus.use_done  = ud;
        if (r) begin
            m_words.delete();
            {m_pend, m_commit, m_zero, m_in_use, m_kv, m_err} = '0;
        end else begin
            nu  = (m_in_use && !ud) || (us && m_kv);
            kvn = m_commit ? 1'b1 : (m_zero ? 1'b0 : m_kv);
            if (k) begin
                m_words.delete();
                {m_pend, m_commit, m_in_use, m_err} = '0;
                m_zero = 1'b1;
            end else if (a && !m_zero) begin
                m_words.delete();
                {m_pend, m_commit, m_zero, m_err} = '0;
                m_in_use = nu;
            end else begin
                m_in_use = nu;
                if (m_commit || m_zero) begin
                    if (w) m_err = 1'b1;
                    m_commit = 1'b0;
                    m_zero   = 1'b0;
                end else if (m_pend) begin
                    if (w) m_err = 1'b1;
                    if (!nu) begin
                        start_commit();
                        m_pend = 1'b0;
                    end
                end else if (w) begin
                    m_words.push_back(d);
                    if (m_words.size() == 4) begin
                        if (nu) m_pend = 1'b1;
                        else start_commit();
                    end
                end
            end
            m_kv = kvn;
        end
    endtask

    task automatic step(input bit r, input bit k, input bit a, input bit w,
                        input logic [31:0] d, input bit us, input bit ud);
        tick_check();
        drive(r, k, a, w, d, us, ud);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic wr(input logic [31:0] d);
        step(0, 0, 0, 1, d, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        @(posedge clk);
        step(1, 0, 0, 0, 32'h0, 0, 0);
        idle();

        // Plain load with the engine idle
        wr(32'h11111111); wr(32'h22222222); wr(32'h33333333); wr(32'h44444444);
        tick_check();
        check_eq("t1_ce", 128'(bus.reg_ce), 128'h1);
        check_eq("t1_data", bus.reg_in, 128'h44444444_33333333_22222222_11111111);
        check_eq("t1_kv_before", 128'(bus.key_valid), 128'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        tick_check();
        check_eq("t1_kv", 128'(bus.key_valid), 128'h1);
        check_eq("t1_ce_off", 128'(bus.reg_ce), 128'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);

        // Load while the engine holds the key
        step(0, 0, 0, 0, 32'h0, 1, 0);
        wr(32'hB0B0B0B0); wr(32'hB1B1B1B1); wr(32'hB2B2B2B2); wr(32'hB3B3B3B3);
        tick_check();
        check_eq("t2_pend", 128'(bus.commit_pend), 128'h1);
        check_eq("t2_no_ce", 128'(bus.reg_ce), 128'h0);
        drive(0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        tick_check();
        check_eq("t2_err", 128'(bus.err_drop), 128'h1);
        drive(0, 0, 0, 0, 32'h0, 0, 1);
        tick_check();
        check_eq("t2_ce", 128'(bus.reg_ce), 128'h1);
        check_eq("t2_data", bus.reg_in, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        tick_check();
        check_eq("t2_kv", 128'(bus.key_valid), 128'h1);
        drive(0, 0, 0, 0, 32'h0, 0, 0);

        // Abort mid-load, then a fresh load
        wr(32'hEEEEEEEE); wr(32'hFFFFFFFF);
        step(0, 0, 1, 0, 32'h0, 0, 0);
        wr(32'hA); wr(32'hB); wr(32'hC); wr(32'hD);
        tick_check();
        check_eq("t3_data", bus.reg_in, 128'h0000000D_0000000C_0000000B_0000000A);
        check_eq("t3_err_clr", 128'(bus.err_drop), 128'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);

        // Kill while in use; later use_start is ignored
        step(0, 0, 0, 0, 32'h0, 1, 0);
        idle();
        step(0, 1, 0, 0, 32'h0, 0, 0);
        tick_check();
        check_eq("t4_zero_ce", 128'(bus.reg_ce), 128'h1);
        check_eq("t4_zero_in", bus.reg_in, 128'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        tick_check();
        check_eq("t4_kv", 128'(bus.key_valid), 128'h0);
        drive(0, 0, 0, 0, 32'h0, 1, 0);
        wr(32'h5); wr(32'h6); wr(32'h7); wr(32'h8);
        tick_check();
        check_eq("t4_immediate", 128'(bus.reg_ce), 128'h1);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        idle();

        // Back-to-back start+done keeps the engine busy; kill beats abort
        step(0, 0, 0, 0, 32'h0, 1, 0);
        step(0, 0, 0, 0, 32'h0, 1, 1);
        wr(32'h1); wr(32'h2); wr(32'h3); wr(32'h4);
        tick_check();
        check_eq("t5_pend", 128'(bus.commit_pend), 128'h1);
        drive(0, 1, 1, 0, 32'h0, 0, 0);
        tick_check();
        check_eq("t5_zero", 128'(bus.reg_ce), 128'h1);
        check_eq("t5_zero_in", bus.reg_in, 128'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);

        // Reset mid-load leaks nothing
        wr(32'h99999999); wr(32'h88888888); wr(32'h77777777);
        step(1, 0, 0, 0, 32'h0, 0, 0);
        tick_check();
        check_eq("t6_busy", 128'(bus.load_busy), 128'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        wr(32'hC0); wr(32'hC1); wr(32'hC2); wr(32'hC3);
        tick_check();
        check_eq("t6_data", bus.reg_in, 128'h000000C3_000000C2_000000C1_000000C0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 4, $urandom,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0);
        end
        tick_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
